// File: rtl/dingshi_pkg.sv
// dingshi_pkg: shared state encoding, default timing constants and counter-width helper
package dingshi_pkg;
  typedef enum logic [2:0] {IDLE, ARM, RUN, GAP, ALARM} state_t;
  localparam int DEF_REPEAT    = 3;
  localparam int DEF_GAP_CYC   = 4;
  localparam int DEF_ALARM_CYC = 16;
  localparam int DEF_BLINK_DIV = 2;
  localparam int DEF_WDOG_CYC  = 64;
  localparam logic [3:0] RUN_CNT_MAX = 4'd15;
  function automatic int cw(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dingshi_blink.sv
// dingshi_blink: alarm blinker, starts high and toggles every BLINK_DIV enabled cycles
// clk/rst: clock, async active-low reset
// en: alarm phase active next cycle; first: phase is being entered
// alarm: registered blink output, low whenever en is low
module dingshi_blink import dingshi_pkg::*; #(
  parameter int BLINK_DIV = DEF_BLINK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic first,
  output logic alarm
);
  localparam int DW = cw(BLINK_DIV);
  logic [DW-1:0] div;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      div   <= '0;
      alarm <= 1'b0;
    end else if (!en || first) begin
      div   <= '0;
      alarm <= en;
    end else if (div == DW'(BLINK_DIV - 1)) begin
      div   <= '0;
      alarm <= ~alarm;
    end else begin
      div <= div + 1'b1;
    end
endmodule

// File: rtl/dingshi_ctrl.sv
// dingshi_ctrl: countdown-timer initiator running REPEAT timed runs, then a blinking alarm, with watchdog
// clk/rst: clock, async active-low reset
// start: request (IDLE only); cancel: abort to IDLE; done_in: sticky timer done flag
// open: timer enable; tmr_rst_n: timer reload (low in ARM); busy: not IDLE
// alarm: blink during ALARM; err: sticky watchdog error; run_cnt: completed runs
module dingshi_ctrl import dingshi_pkg::*; #(
  parameter int REPEAT    = DEF_REPEAT,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int ALARM_CYC = DEF_ALARM_CYC,
  parameter int BLINK_DIV = DEF_BLINK_DIV,
  parameter int WDOG_CYC  = DEF_WDOG_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cancel,
  input  logic       done_in,
  output logic       open,
  output logic       tmr_rst_n,
  output logic       busy,
  output logic       alarm,
  output logic       err,
  output logic [3:0] run_cnt
);
  localparam int WW = cw(WDOG_CYC);
  localparam int GW = cw(GAP_CYC);
  localparam int AW = cw(ALARM_CYC);
  state_t state, nxt;
  logic [WW-1:0] wd;
  logic [GW-1:0] gap_cnt;
  logic [AW-1:0] alm_cnt;
  logic done_ok, wd_exp, gap_end, alm_end, last_run, accept, incr, wd_err;
  // done in the first RUN cycle may be stale from before the reload
  always_comb begin
    done_ok  = done_in && wd != '0;
    wd_exp   = wd == WW'(WDOG_CYC - 1);
    gap_end  = gap_cnt == GW'(GAP_CYC - 1);
    alm_end  = alm_cnt == AW'(ALARM_CYC - 1);
    last_run = {1'b0, run_cnt} + 5'd1 == 5'(REPEAT);
  end
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = start && !cancel ? ARM : IDLE;
      ARM:     nxt = cancel ? IDLE : RUN;
      RUN:     nxt = cancel ? IDLE : done_ok ? (last_run ? ALARM : GAP) : wd_exp ? IDLE : RUN;
      GAP:     nxt = cancel ? IDLE : gap_end ? ARM : GAP;
      ALARM:   nxt = cancel || alm_end ? IDLE : ALARM;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    accept = state == IDLE && nxt == ARM;
    incr   = state == RUN && !cancel && done_ok;
    wd_err = state == RUN && !cancel && !done_ok && wd_exp;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      wd        <= '0;
      gap_cnt   <= '0;
      alm_cnt   <= '0;
      open      <= 1'b0;
      tmr_rst_n <= 1'b1;
      busy      <= 1'b0;
      err       <= 1'b0;
      run_cnt   <= '0;
    end else begin
      state     <= nxt;
      wd        <= state == RUN && nxt == RUN ? wd + 1'b1 : '0;
      gap_cnt   <= state == GAP && nxt == GAP ? gap_cnt + 1'b1 : '0;
      alm_cnt   <= state == ALARM && nxt == ALARM ? alm_cnt + 1'b1 : '0;
      open      <= nxt == RUN;
      tmr_rst_n <= nxt != ARM;
      busy      <= nxt != IDLE;
      err       <= accept ? 1'b0 : err | wd_err;
      run_cnt   <= accept ? '0 : incr && run_cnt != RUN_CNT_MAX ? run_cnt + 1'b1 : run_cnt;
    end
  dingshi_blink #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk  (clk),
    .rst  (rst),
    .en   (nxt == ALARM),
    .first(state != ALARM),
    .alarm(alarm)
  );
endmodule

// File: tb/tb_dingshi_ctrl.sv
// tb_dingshi_ctrl: directed bench with a procedural timeline model and per-cycle output compare
module tb_dingshi_ctrl;
  localparam int REP = 3, GAPC = 4, ALMC = 16, BDIV = 2, WDOG = 64;
  logic clk = 0, rst = 1, start = 0, cancel = 0, dforce = 0;
  logic open, tmr_rst_n, busy, alarm, err, done_in;
  logic [3:0] run_cnt;
  int dly = 6, tcnt = 0;
  logic tdone = 0;
  int n_chk = 0, n_err = 0;
  bit chk_on = 0;
  int rst_ev = 0, seen_ev = 0;
  int m_arm = 0, m_open = 0, m_alarm = 0, m_busy = 0;
  logic e_open = 0, e_trn = 1, e_busy = 0, e_alarm = 0, e_err = 0;
  int e_cnt = 0;
  logic s_start, s_cancel, s_done;

  always #5 clk = ~clk;
  assign done_in = tdone | dforce;

  dingshi_ctrl #(.REPEAT(REP), .GAP_CYC(GAPC), .ALARM_CYC(ALMC), .BLINK_DIV(BDIV), .WDOG_CYC(WDOG)) dut (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel), .done_in(done_in),
    .open(open), .tmr_rst_n(tmr_rst_n), .busy(busy), .alarm(alarm), .err(err), .run_cnt(run_cnt)
  );

  // timer: reloads while tmr_rst_n low, counts open cycles, raises sticky done at dly (0 = never)
  always @(negedge clk)
    if (!tmr_rst_n) begin
      tcnt  <= 0;
      tdone <= 1'b0;
    end else if (open) begin
      tcnt <= tcnt + 1;
      if (dly != 0 && tcnt + 1 >= dly) tdone <= 1'b1;
    end

  always @(negedge rst) rst_ev <= rst_ev + 1;

  always @(negedge clk)
    if (rst) begin
      m_arm   <= m_arm + int'(!tmr_rst_n);
      m_open  <= m_open + int'(open);
      m_alarm <= m_alarm + int'(alarm);
      m_busy  <= m_busy + int'(busy);
    end

  // model: one clock edge; abort on reset (even a short pulse) or cancel
  task automatic tick(output bit a);
    @(posedge clk);
    s_start = start;
    s_cancel = cancel;
    s_done = done_in;
    a = !rst || rst_ev != seen_ev || s_cancel;
    if (!rst || rst_ev != seen_ev) begin
      e_open = 0; e_trn = 1; e_busy = 0; e_alarm = 0; e_err = 0; e_cnt = 0;
    end else if (s_cancel) begin
      e_open = 0; e_trn = 1; e_busy = 0; e_alarm = 0;
    end
    seen_ev = rst_ev;
  endtask

  task automatic run_seq();
    bit a, got;
    int n;
    e_err = 0; e_cnt = 0; e_busy = 1;
    forever begin
      e_trn = 0; e_open = 0;
      tick(a); if (a) return;
      e_trn = 1; e_open = 1; n = 0; got = 0;
      while (1) begin
        tick(a); if (a) return;
        if (s_done && n > 0) begin got = 1; break; end
        if (n == WDOG - 1) break;
        n++;
      end
      e_open = 0;
      if (!got) begin e_err = 1; e_busy = 0; return; end
      e_cnt = e_cnt < 15 ? e_cnt + 1 : 15;
      if (e_cnt == REP) begin
        e_alarm = 1;
        for (int i = 1; i < ALMC; i++) begin
          tick(a); if (a) return;
          e_alarm = ((i / BDIV) % 2) == 0;
        end
        tick(a); if (a) return;
        e_alarm = 0; e_busy = 0;
        return;
      end
      for (int i = 0; i < GAPC; i++) begin
        tick(a); if (a) return;
      end
    end
  endtask

  initial begin : model
    forever begin
      bit a;
      tick(a);
      if (!a && s_start) run_seq();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 300 && busy; k++) @(negedge clk);
    chk(nm, busy, 0);
  endtask

  initial begin
    int a0, o0, al0, b0;
    fork
      forever begin
        @(negedge clk);
        if (chk_on) begin
          chk("open", open, rst ? e_open : 1'b0);
          chk("tmr_rst_n", tmr_rst_n, rst ? e_trn : 1'b1);
          chk("busy", busy, rst ? e_busy : 1'b0);
          chk("alarm", alarm, rst ? e_alarm : 1'b0);
          chk("err", err, rst ? e_err : 1'b0);
          chk("run_cnt", run_cnt, rst ? e_cnt : 0);
        end
      end
      begin
        rst = 0;
        repeat (3) @(negedge clk);
        chk_on = 1;
        #2 rst = 1;
        repeat (20) @(negedge clk);
        chk("idle_open", open, 0);
        chk("idle_busy", busy, 0);
        chk("idle_trn", tmr_rst_n, 1);
        // normal three-run sequence
        a0 = m_arm; o0 = m_open; al0 = m_alarm; b0 = m_busy;
        pulse_start();
        wait_idle("norm_idle");
        chk("norm_arms", m_arm - a0, 3);
        chk("norm_open", m_open - o0, 18);
        chk("norm_alarm_hi", m_alarm - al0, 8);
        chk("norm_busy", m_busy - b0, 45);
        chk("norm_cnt", run_cnt, 3);
        // watchdog: timer never finishes
        dly = 0;
        a0 = m_arm; o0 = m_open; b0 = m_busy;
        pulse_start();
        wait_idle("wd_idle");
        chk("wd_err", err, 1);
        chk("wd_open", m_open - o0, 64);
        chk("wd_busy", m_busy - b0, 65);
        chk("wd_arms", m_arm - a0, 1);
        dly = 6;
        pulse_start();
        chk("wd_err_clr", err, 0);
        wait_idle("wd2_idle");
        chk("wd2_cnt", run_cnt, 3);
        // cancel during run 2
        al0 = m_alarm;
        pulse_start();
        for (int k = 0; k < 100 && run_cnt != 1; k++) @(negedge clk);
        chk("can_wait_rc", run_cnt, 1);
        for (int k = 0; k < 100 && !open; k++) @(negedge clk);
        chk("can_wait_open", open, 1);
        repeat (2) @(negedge clk);
        cancel = 1;
        @(negedge clk) cancel = 0;
        chk("can_open", open, 0);
        chk("can_busy", busy, 0);
        chk("can_cnt", run_cnt, 1);
        repeat (10) @(negedge clk);
        chk("can_alarm", m_alarm - al0, 0);
        // start held high while busy
        a0 = m_arm;
        @(negedge clk) start = 1;
        repeat (10) @(negedge clk);
        start = 0;
        wait_idle("hold_idle");
        chk("hold_arms", m_arm - a0, 3);
        // done and cancel together
        dly = 0;
        pulse_start();
        for (int k = 0; k < 10 && !open; k++) @(negedge clk);
        chk("dc_wait_open", open, 1);
        @(negedge clk) begin dforce = 1; cancel = 1; end
        @(negedge clk) begin dforce = 0; cancel = 0; end
        chk("dc_cnt", run_cnt, 0);
        chk("dc_busy", busy, 0);
        // stale done in the first RUN cycle
        dly = 6;
        o0 = m_open;
        pulse_start();
        for (int k = 0; k < 10 && tmr_rst_n; k++) @(negedge clk);
        chk("st_wait_arm", tmr_rst_n, 0);
        @(negedge clk) dforce = 1;
        @(negedge clk) dforce = 0;
        wait_idle("st_idle");
        chk("st_open", m_open - o0, 18);
        chk("st_cnt", run_cnt, 3);
        // async reset mid-GAP
        pulse_start();
        for (int k = 0; k < 100 && run_cnt != 1; k++) @(negedge clk);
        chk("ar_wait_gap", run_cnt, 1);
        #2 rst = 0;
        #1;
        chk("ar_open", open, 0);
        chk("ar_busy", busy, 0);
        chk("ar_cnt", run_cnt, 0);
        @(negedge clk);
        #2 rst = 1;
        repeat (8) @(negedge clk);
        chk("ar_idle", busy, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
      end
    join
  end
endmodule
